// File: rtl/button_event_decoder.sv
// Synchronises, debounces and classifies active-low button pins into a press/release event stream.
// Define BTN_LONGPRESS_EN to add hold counters and the LONG / RELEASE_LONG events.
module button_event_decoder #(
  parameter int NBTN      = 2,
  parameter int DB_LOG2   = 18,
  parameter int LONG_LOG2 = 25
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_n,
  output logic [NBTN-1:0] btn_level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [2:0]      evt_btn,
  output logic [1:0]      evt_code,
  output logic            evt_overflow
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [1:0] CODE_PRESS        = 2'b00;
  localparam logic [1:0] CODE_RELEASE      = 2'b01;
  localparam logic [1:0] CODE_LONG         = 2'b10;
  localparam logic [1:0] CODE_RELEASE_LONG = 2'b11;

  localparam logic [DB_LOG2-1:0] DB_MAX = '1;

  if (NBTN < 1 || NBTN > 8 || DB_LOG2 < 1 || LONG_LOG2 < 1) begin : g_param_check
    $error("button_event_decoder: illegal parameter value");
  end

  logic [NBTN-1:0]    sync1, sync2, raw;
  logic [DB_LOG2-1:0] db_cnt [NBTN];
  state_t             state [NBTN];
  logic [NBTN-1:0]    emit, pend_valid, take, dropped;
  logic [1:0]         emit_code [NBTN];
  logic [1:0]         pend_code [NBTN];
  logic               load, sel_found;
  logic [2:0]         sel_idx;
  logic [1:0]         sel_code;

`ifdef BTN_LONGPRESS_EN
  localparam logic [LONG_LOG2-1:0] HOLD_MAX = '1;
  logic [LONG_LOG2-1:0] hold [NBTN];
`endif

  assign raw  = ~sync2;
  assign load = !evt_valid || evt_ready;

  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      emit[i]      = 1'b0;
      emit_code[i] = CODE_PRESS;
      case (state[i])
        IDLE: begin
          if (btn_level[i]) begin
            emit[i]      = 1'b1;
            emit_code[i] = CODE_PRESS;
          end
        end
        PRESSED: begin
          // A fall coinciding with the threshold is reported as a plain release.
          if (!btn_level[i]) begin
            emit[i]      = 1'b1;
            emit_code[i] = CODE_RELEASE;
          end
`ifdef BTN_LONGPRESS_EN
          else if (hold[i] == HOLD_MAX) begin
            emit[i]      = 1'b1;
            emit_code[i] = CODE_LONG;
          end
`endif
        end
`ifdef BTN_LONGPRESS_EN
        LONG: begin
          if (!btn_level[i]) begin
            emit[i]      = 1'b1;
            emit_code[i] = CODE_RELEASE_LONG;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Fixed priority: lowest-index pending slot feeds the output register.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 3'd0;
    sel_code  = CODE_PRESS;
    take      = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (pend_valid[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        sel_code  = pend_code[i];
        take[i]   = load;
      end
    end
  end

  // A slot being drained this cycle can accept a new event.
  assign dropped = emit & pend_valid & ~take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1        <= '1;
      sync2        <= '1;
      btn_level    <= '0;
      pend_valid   <= '0;
      evt_valid    <= 1'b0;
      evt_btn      <= 3'd0;
      evt_code     <= 2'b00;
      evt_overflow <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        db_cnt[i]    <= '0;
        state[i]     <= IDLE;
        pend_code[i] <= 2'b00;
`ifdef BTN_LONGPRESS_EN
        hold[i]      <= '0;
`endif
      end
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;

      for (int i = 0; i < NBTN; i++) begin
        if (raw[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          btn_level[i] <= ~btn_level[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end

        case (state[i])
          IDLE: begin
            if (btn_level[i]) begin
              state[i] <= PRESSED;
`ifdef BTN_LONGPRESS_EN
              hold[i]  <= '0;
`endif
            end
          end
          PRESSED: begin
            if (!btn_level[i]) begin
              state[i] <= IDLE;
            end
`ifdef BTN_LONGPRESS_EN
            else if (hold[i] == HOLD_MAX) begin
              state[i] <= LONG;
            end else begin
              hold[i] <= hold[i] + 1'b1;
            end
`endif
          end
          LONG: begin
            if (!btn_level[i]) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase

        if (emit[i] && (!pend_valid[i] || take[i])) begin
          pend_valid[i] <= 1'b1;
          pend_code[i]  <= emit_code[i];
        end else if (take[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end

      evt_overflow <= |dropped;

      if (load) begin
        evt_valid <= sel_found;
        if (sel_found) begin
          evt_btn  <= sel_idx;
          evt_code <= sel_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder (NBTN=2, DB_LOG2=3, LONG_LOG2=6).
module tb_button_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_n;
  logic [1:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_btn;
  logic [1:0] evt_code;
  logic       evt_overflow;

  button_event_decoder #(.NBTN(2), .DB_LOG2(3), .LONG_LOG2(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_level    (btn_level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_btn      (evt_btn),
    .evt_code     (evt_code),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] b;
    logic [1:0] c;
    int         t;
  } evt_t;

  evt_t       q[$];
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         rise_t [2];
  logic [1:0] lvl_prev = 2'b00;
  int         n_cmp = 0;
  int         n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Transfers are recorded on the falling edge preceding the accepting rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (evt_valid && evt_ready) q.push_back('{evt_btn, evt_code, cyc});
      if (evt_overflow) ovf_cnt++;
      for (int i = 0; i < 2; i++)
        if (btn_level[i] && !lvl_prev[i]) rise_t[i] = cyc;
    end
    lvl_prev = btn_level;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input string tag, input int idx, input logic [2:0] b,
                           input logic [1:0] c);
    logic [4:0] obs;
    obs = (idx < q.size()) ? {q[idx].b, q[idx].c} : 5'bxxxxx;
    chk(tag, {27'd0, obs}, {27'd0, b, c});
  endtask

  task automatic drive_after(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_q(input string tag, input int n, input int budget);
    int k = 0;
    while (q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, q.size() >= n}, 32'd1);
  endtask

  task automatic wait_level(input string tag, input logic [1:0] exp, input int budget);
    int k = 0;
    while (btn_level !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {30'd0, btn_level}, {30'd0, exp});
  endtask

  initial begin
    int   lat;
    logic seen;
    int   ovf0;

    rst       = 1'b1;
    btn_n     = 2'b00;
    evt_ready = 1'b1;

    // 1: reset while both buttons are held
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_outputs", {24'd0, btn_level, evt_valid, evt_btn, evt_code, evt_overflow}, 32'd0);
    end
    drive_after(1);
    rst = 1'b0;
    wait_level("t1_level", 2'b11, 30);
    wait_q("t1_q", 2, 20);
    check_evt("t1_press0", 0, 3'd0, 2'b00);
    check_evt("t1_press1", 1, 3'd1, 2'b00);
    lat = (q.size() > 0) ? q[0].t - rise_t[0] : -1;
    chk("t1_latency", lat, 32'd2);
    chk("t1_ovf", ovf_cnt, 32'd0);

    drive_after(1);
    q.delete();
    btn_n = 2'b11;
    wait_q("t1_rel_q", 2, 40);
    check_evt("t1_rel0", 0, 3'd0, 2'b01);
    check_evt("t1_rel1", 1, 3'd1, 2'b01);
    chk("t1_level_off", {30'd0, btn_level}, 32'd0);

    // 2: 5-cycle bounce on btn 0
    drive_after(5);
    q.delete();
    btn_n = 2'b10;
    drive_after(5);
    btn_n = 2'b11;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (btn_level != 2'b00) seen = 1'b1;
    end
    chk("t2_no_level", {31'd0, seen}, 32'd0);
    chk("t2_no_event", q.size(), 32'd0);

    // 3: short press of btn 0
    drive_after(1);
    q.delete();
    btn_n = 2'b10;
    drive_after(40);
    btn_n = 2'b11;
    wait_q("t3_q", 2, 40);
    drive_after(10);
    chk("t3_count", q.size(), 32'd2);
    check_evt("t3_press", 0, 3'd0, 2'b00);
    check_evt("t3_release", 1, 3'd0, 2'b01);
    lat = (q.size() > 0) ? q[0].t - rise_t[0] : -1;
    chk("t3_latency", lat, 32'd2);

    // 4: long press of btn 1
    drive_after(1);
    q.delete();
    btn_n = 2'b01;
    drive_after(200);
    btn_n = 2'b11;
    wait_level("t4_level_off", 2'b00, 30);
    drive_after(6);
`ifdef BTN_LONGPRESS_EN
    chk("t4_count", q.size(), 32'd3);
    check_evt("t4_press", 0, 3'd1, 2'b00);
    check_evt("t4_long", 1, 3'd1, 2'b10);
    check_evt("t4_rel_long", 2, 3'd1, 2'b11);
    lat = (q.size() > 1) ? q[1].t - q[0].t : -1;
    chk("t4_long_delay", lat, 32'd64);
`else
    chk("t4_count", q.size(), 32'd2);
    check_evt("t4_press", 0, 3'd1, 2'b00);
    check_evt("t4_release", 1, 3'd1, 2'b01);
`endif

    // 5: backpressure with simultaneous presses
    drive_after(1);
    q.delete();
    ovf0      = ovf_cnt;
    evt_ready = 1'b0;
    btn_n     = 2'b00;
    begin
      int k = 0;
      while (evt_valid !== 1'b1 && k < 30) begin
        @(negedge clk);
        k++;
      end
    end
    chk("t5_valid", {31'd0, evt_valid}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({evt_valid, evt_btn, evt_code} !== 6'b1_000_00) seen = 1'b1;
    end
    chk("t5_hold_stable", {31'd0, seen}, 32'd0);
    drive_after(1);
    evt_ready = 1'b1;
    drive_after(1);
    evt_ready = 1'b0;
    @(negedge clk);
    chk("t5_next", {26'd0, evt_valid, evt_btn, evt_code}, {26'd0, 6'b1_001_00});
    drive_after(1);
    evt_ready = 1'b1;
    btn_n     = 2'b11;
    drive_after(30);
    chk("t5_count", q.size(), 32'd4);
    check_evt("t5_e0", 0, 3'd0, 2'b00);
    check_evt("t5_e1", 1, 3'd1, 2'b00);
    check_evt("t5_e2", 2, 3'd0, 2'b01);
    check_evt("t5_e3", 3, 3'd1, 2'b01);
    chk("t5_ovf", ovf_cnt - ovf0, 32'd0);

    // 6: pending slot overflow on btn 0
    drive_after(1);
    q.delete();
    ovf0      = ovf_cnt;
    evt_ready = 1'b0;
    btn_n     = 2'b10;
    drive_after(15);
    btn_n = 2'b11;
    drive_after(15);
    btn_n = 2'b10;
    drive_after(25);
    @(negedge clk);
    chk("t6_ovf_once", ovf_cnt - ovf0, 32'd1);
    chk("t6_level", {31'd0, btn_level[0]}, 32'd1);
    chk("t6_head", {26'd0, evt_valid, evt_btn, evt_code}, {26'd0, 6'b1_000_00});
    drive_after(1);
    evt_ready = 1'b1;
    drive_after(4);
    chk("t6_count", q.size(), 32'd2);
    check_evt("t6_press", 0, 3'd0, 2'b00);
    check_evt("t6_release", 1, 3'd0, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
